// File: rtl/wb_deserializer_if.sv
// Wishbone B4 classic bus bundle for the serial-link receiver.
interface wb_deserializer_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [1:0]  ADR_I;
  logic [31:0] DAT_I;
  logic        ACK_O;
  logic        ERR_O;
  logic [31:0] DAT_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    input  ACK_O, ERR_O, DAT_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    output ACK_O, ERR_O, DAT_O
  );
endinterface

// File: rtl/wb_deserializer.sv
// Serial-link receiver: assembles MSB-first words from a qualified bit
// stream, buffers them in a small FIFO and exposes the FIFO plus status
// through a Wishbone B4 classic slave (one wait state).
module wb_deserializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             data_i,
  input  logic             ena_i,
  output logic             irq_o,
  wb_deserializer_if.slave wb
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;

  typedef enum logic [1:0] {
    ADR_RXDATA = 2'd0,
    ADR_STATUS = 2'd1,
    ADR_CTRL   = 2'd2,
    ADR_RSVD   = 2'd3
  } reg_addr_e;

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]         count_q, count_d;
  logic                  rx_en_q, rx_en_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;
  logic [31:0]           dat_q, dat_d;

  logic [DATA_WIDTH:0]   shift_ext;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  push, frame_set;
  logic                  pop, flush, clr_flags;
  logic                  do_push, overflow_set;
  logic                  empty, full, req;
  logic [31:0]           status;
  logic                  unused_bits;

  assign empty  = (count_q == '0);
  assign full   = (count_q == NW'(FIFO_DEPTH));
  assign req    = wb.CYC_I & wb.STB_I & ~ack_q & ~err_q;
  assign status = 32'({8'(count_q), 4'h0, frame_err_q, overflow_q, full, empty});

  assign wb.ACK_O = ack_q;
  assign wb.ERR_O = err_q;
  assign wb.DAT_O = dat_q;
  assign irq_o    = irq_q;

  assign unused_bits = ^{wb.DAT_I[31:3], shift_ext[DATA_WIDTH]};

  // Bit assembly: shift while qualified, flag words cut short by ena_i
  always_comb begin
    shift_ext = {shreg_q, data_i};
    word_next = shift_ext[DATA_WIDTH-1:0];
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    push      = 1'b0;
    frame_set = 1'b0;
    if (!rx_en_q) begin
      bitcnt_d = '0;
    end else if (ena_i) begin
      shreg_d = word_next;
      if (bitcnt_q == CW'(DATA_WIDTH - 1)) begin
        push     = 1'b1;
        bitcnt_d = '0;
      end else begin
        bitcnt_d = bitcnt_q + CW'(1);
      end
    end else if (bitcnt_q != '0) begin
      bitcnt_d  = '0;
      frame_set = 1'b1;
    end
  end

  // Wishbone decode: terminate every request on the following edge
  always_comb begin
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    pop       = 1'b0;
    flush     = 1'b0;
    clr_flags = 1'b0;
    rx_en_d   = rx_en_q;
    if (req) begin
      case (reg_addr_e'(wb.ADR_I))
        ADR_RXDATA: begin
          if (wb.WE_I) begin
            err_d = 1'b1;
          end else if (empty) begin
            err_d = 1'b1;
            dat_d = '0;
          end else begin
            ack_d = 1'b1;
            dat_d = 32'(mem_q[rd_ptr_q]);
            pop   = 1'b1;
          end
        end
        ADR_STATUS: begin
          if (wb.WE_I) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            dat_d = status;
          end
        end
        ADR_CTRL: begin
          ack_d = 1'b1;
          if (wb.WE_I) begin
            rx_en_d   = wb.DAT_I[0];
            flush     = wb.DAT_I[1];
            clr_flags = wb.DAT_I[2];
          end else begin
            dat_d = 32'(rx_en_q);
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // FIFO bookkeeping; flush discards any word completing on the same edge
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    do_push      = push & (~full | pop);
    overflow_set = push & full & ~pop & ~flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = word_next;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + NW'(do_push) - NW'(pop);
    end
  end

  // Sticky flags: a same-edge event takes priority over a clear request
  always_comb begin
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    irq_d       = ~empty;
    if (clr_flags) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (overflow_set) overflow_d  = 1'b1;
    if (frame_set)    frame_err_d = 1'b1;
  end

  // State registers
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_en_q     <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_en_q     <= rx_en_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      dat_q       <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_deserializer.sv
// Directed + randomized bench for wb_deserializer against a word-level
// queue model of the receive FIFO and its status flags.
module tb_wb_deserializer;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic data_i;
  logic ena_i;
  logic irq_o;

  wb_deserializer_if wb ();

  wb_deserializer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst_n),
    .data_i(data_i),
    .ena_i (ena_i),
    .irq_o (irq_o),
    .wb    (wb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered words, enable and sticky flags
  logic [7:0] q[$];
  logic m_rx_en, m_ovf, m_ferr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(q.size()), 4'h0, m_ferr, m_ovf, (q.size() == DEPTH), (q.size() == 0)};
  endfunction

  task automatic wb_cycle(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                          output logic ack, output logic err, output logic [31:0] rdat);
    @(negedge clk);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = we; wb.ADR_I = adr; wb.DAT_I = wdat;
    @(posedge clk); #1;
    ack = wb.ACK_O; err = wb.ERR_O; rdat = wb.DAT_O;
    @(negedge clk);
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
    @(posedge clk); #1;
    check("term_one_cycle", {30'b0, wb.ACK_O, wb.ERR_O}, 32'h0);
  endtask

  task automatic rd_rx(input string tag);
    logic a, e; logic [31:0] d;
    wb_cycle(1'b0, 2'd0, 32'h0, a, e, d);
    if (q.size() == 0) begin
      check({tag, "_err"}, {30'b0, a, e}, 32'h1);
      check({tag, "_dat0"}, d, 32'h0);
    end else begin
      logic [31:0] exp;
      exp = 32'(q.pop_front());
      check({tag, "_ack"}, {30'b0, a, e}, 32'h2);
      check({tag, "_dat"}, d, exp);
    end
  endtask

  task automatic rd_status(input string tag);
    logic a, e; logic [31:0] d, exp;
    exp = exp_status();
    wb_cycle(1'b0, 2'd1, 32'h0, a, e, d);
    check({tag, "_ack"}, {30'b0, a, e}, 32'h2);
    check({tag, "_val"}, d, exp);
  endtask

  task automatic rd_ctrl(input string tag);
    logic a, e; logic [31:0] d;
    wb_cycle(1'b0, 2'd2, 32'h0, a, e, d);
    check({tag, "_ack"}, {30'b0, a, e}, 32'h2);
    check({tag, "_val"}, d, {31'b0, m_rx_en});
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    logic a, e; logic [31:0] d;
    wb_cycle(1'b1, 2'd2, v, a, e, d);
    check("ctrl_wr_ack", {30'b0, a, e}, 32'h2);
    m_rx_en = v[0];
    if (v[1]) q.delete();
    if (v[2]) begin m_ovf = 1'b0; m_ferr = 1'b0; end
  endtask

  task automatic err_access(input logic we, input logic [1:0] adr, input string tag);
    logic a, e; logic [31:0] d;
    wb_cycle(we, adr, $urandom, a, e, d);
    check(tag, {30'b0, a, e}, 32'h1);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = DW - 1; i >= 0; i--) begin
      @(negedge clk); data_i = w[i]; ena_i = 1'b1;
    end
    @(negedge clk); ena_i = 1'b0; data_i = 1'($urandom);
    if (m_rx_en) begin
      if (q.size() < DEPTH) q.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); data_i = 1'($urandom); ena_i = 1'b1;
    end
    @(negedge clk); ena_i = 1'b0;
    if (m_rx_en && n > 0) m_ferr = 1'b1;
  endtask

  task automatic check_irq(input string tag);
    @(posedge clk); #1;
    check(tag, {31'b0, irq_o}, {31'b0, q.size() != 0});
  endtask

  // RXDATA read terminating on the edge that samples the last bit of a new word
  task automatic push_pop_same_edge(input logic [7:0] w);
    logic [31:0] exp;
    for (int i = DW - 1; i >= 1; i--) begin
      @(negedge clk); data_i = w[i]; ena_i = 1'b1;
    end
    @(negedge clk);
    data_i = w[0];
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.ADR_I = 2'd0;
    @(posedge clk); #1;
    exp = 32'(q.pop_front());
    q.push_back(w);
    check("pp_ack", {30'b0, wb.ACK_O, wb.ERR_O}, 32'h2);
    check("pp_dat", wb.DAT_O, exp);
    @(negedge clk);
    ena_i = 1'b0; wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    rst_n = 1'b0; data_i = 1'b0; ena_i = 1'b0;
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0; wb.ADR_I = 2'd0; wb.DAT_I = 32'h0;
    m_rx_en = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack_err_irq", {29'b0, wb.ACK_O, wb.ERR_O, irq_o}, 32'h0);
    check("rst_dat", wb.DAT_O, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    rd_status("rst_status");
    rd_ctrl("rst_ctrl");

    // Single word
    wr_ctrl(32'h1);
    send_word(8'hA5);
    rd_status("t1_status");
    check_irq("t1_irq_set");
    rd_rx("t1_rx");
    rd_status("t1_status_after");
    check_irq("t1_irq_clr");

    // Overflow with five words into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_word(8'(i));
    rd_status("t2_status_full_ovf");
    for (int i = 0; i < 5; i++) rd_rx("t2_rx");
    wr_ctrl(32'h5);
    rd_status("t2_status_clr");

    // Truncated word followed by a good word
    send_partial(3);
    send_word(8'h3C);
    rd_status("t3_status_ferr");
    rd_rx("t3_rx");
    wr_ctrl(32'h5);

    // Simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) send_word(8'($urandom));
    rd_status("t4_status_full");
    push_pop_same_edge(8'($urandom));
    rd_status("t4_status_pp");
    for (int i = 0; i < DEPTH + 1; i++) rd_rx("t4_rx");

    // Error terminations and disabled receiver
    send_word(8'($urandom));
    err_access(1'b0, 2'd3, "t5_rd_adr3");
    err_access(1'b1, 2'd3, "t5_wr_adr3");
    err_access(1'b1, 2'd0, "t5_wr_rxdata");
    err_access(1'b1, 2'd1, "t5_wr_status");
    rd_status("t5_status_unchanged");
    wr_ctrl(32'h0);
    rd_ctrl("t5_ctrl_off");
    send_partial(3);
    send_word(8'($urandom));
    rd_status("t5_status_disabled");
    wr_ctrl(32'h1);
    rd_rx("t5_rx");
    rd_rx("t5_rx_empty");

    // Randomized mix of traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1: send_word(8'($urandom));
        2:    rd_rx("rnd_rx");
        default: rd_status("rnd_status");
      endcase
    end
    check_irq("rnd_irq");
    wr_ctrl(32'h3);
    rd_status("rnd_flush_status");
    wr_ctrl(32'h5);

    // Asynchronous reset mid-word with a read terminating
    send_word(8'($urandom));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); data_i = 1'($urandom); ena_i = 1'b1;
    end
    @(negedge clk);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.ADR_I = 2'd0;
    @(posedge clk); #1;
    check("t6_pre_rst_ack", {31'b0, wb.ACK_O}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ack_err_irq", {29'b0, wb.ACK_O, wb.ERR_O, irq_o}, 32'h0);
    check("t6_rst_dat", wb.DAT_O, 32'h0);
    ena_i = 1'b0; wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
    q.delete(); m_rx_en = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    rd_status("t6_status");
    rd_ctrl("t6_ctrl");
    wr_ctrl(32'h1);
    w = 8'($urandom);
    send_word(w);
    rd_status("t6_status_word");
    rd_rx("t6_rx");
    check_irq("t6_irq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
